// File: rtl/tt_um_frequency_counter_pkg.sv
// Shared widths, byte-select encodings and uio bit positions for the frequency counter.
package tt_um_frequency_counter_pkg;

   localparam int COUNT_W = 24;
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   typedef enum logic [1:0] {
      SEL_B0   = 2'b00,
      SEL_B1   = 2'b01,
      SEL_B2   = 2'b10,
      SEL_STAT = 2'b11
   } byte_sel_e;

   localparam int UIO_STROBE = 0;
   localparam int UIO_VALID  = 1;
   localparam int UIO_TOGGLE = 2;
   localparam logic [7:0] UIO_OE_VAL = 8'b0000_0111;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt, input logic inc);
      if (inc && (cnt != COUNT_MAX)) begin
         return cnt + COUNT_W'(1);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/freq_gate_counter.sv
// Synchronises the signal under test, counts its rising edges over a gate window
// and latches the count at the end of each window.
module freq_gate_counter
   import tt_um_frequency_counter_pkg::*;
#(
   parameter int GATE_LONG  = 50_000_000,
   parameter int GATE_SHORT = 5_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sig_in,
   input  logic               range_in,
   output logic [COUNT_W-1:0] result,
   output logic               overflow,
   output logic               valid,
   output logic               toggle,
   output logic               strobe
);

   localparam int GMAX = (GATE_LONG > GATE_SHORT) ? GATE_LONG : GATE_SHORT;
   localparam int GW   = (GMAX > 2) ? $clog2(GMAX) : 1;
   localparam logic [GW-1:0] LAST_LONG  = GW'(GATE_LONG - 1);
   localparam logic [GW-1:0] LAST_SHORT = GW'(GATE_SHORT - 1);

   logic               sig_s1_q, sig_s2_q, sig_prev_q;
   logic               rng_s1_q, rng_s2_q, rng_prev_q;
   logic               run_q;
   logic [GW-1:0]      gate_q, gate_d;
   logic [COUNT_W-1:0] edge_q, edge_d;
   logic               ovf_win_q, ovf_win_d;
   logic [COUNT_W-1:0] result_q, result_d;
   logic               overflow_q, overflow_d;
   logic               valid_q, valid_d;
   logic               toggle_q, toggle_d;
   logic               strobe_q, strobe_d;
   logic               detect, rng_chg, terminal;

   always_comb begin
      detect     = sig_s2_q & ~sig_prev_q;
      rng_chg    = rng_s2_q ^ rng_prev_q;
      terminal   = run_q && (gate_q == (rng_s2_q ? LAST_SHORT : LAST_LONG));
      gate_d     = gate_q;
      edge_d     = edge_q;
      ovf_win_d  = ovf_win_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      valid_d    = valid_q;
      toggle_d   = toggle_q;
      strobe_d   = 1'b0;
      // A range switch abandons the running window without publishing it.
      if (rng_chg) begin
         gate_d    = '0;
         edge_d    = '0;
         ovf_win_d = 1'b0;
      end else if (terminal) begin
         gate_d     = '0;
         result_d   = sat_inc(edge_q, detect);
         overflow_d = ovf_win_q | (detect && (edge_q == COUNT_MAX));
         edge_d     = '0;
         ovf_win_d  = 1'b0;
         valid_d    = 1'b1;
         toggle_d   = ~toggle_q;
         strobe_d   = 1'b1;
      end else begin
         if (run_q) begin
            gate_d = gate_q + GW'(1);
         end
         edge_d = sat_inc(edge_q, detect);
         if (detect && (edge_q == COUNT_MAX)) begin
            ovf_win_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_s1_q   <= 1'b0;
         sig_s2_q   <= 1'b0;
         sig_prev_q <= 1'b0;
         rng_s1_q   <= 1'b0;
         rng_s2_q   <= 1'b0;
         rng_prev_q <= 1'b0;
         run_q      <= 1'b0;
         gate_q     <= '0;
         edge_q     <= '0;
         ovf_win_q  <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
         toggle_q   <= 1'b0;
         strobe_q   <= 1'b0;
      end else begin
         sig_s1_q   <= sig_in;
         sig_s2_q   <= sig_s1_q;
         sig_prev_q <= sig_s2_q;
         rng_s1_q   <= range_in;
         rng_s2_q   <= rng_s1_q;
         rng_prev_q <= rng_s2_q;
         run_q      <= 1'b1;
         gate_q     <= gate_d;
         edge_q     <= edge_d;
         ovf_win_q  <= ovf_win_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
         toggle_q   <= toggle_d;
         strobe_q   <= strobe_d;
      end
   end

   assign result   = result_q;
   assign overflow = overflow_q;
   assign valid    = valid_q;
   assign toggle   = toggle_q;
   assign strobe   = strobe_q;

endmodule

// File: rtl/tt_um_frequency_counter.sv
// Frequency counter tile wrapper: result byte mux and uio tie-offs around the gate counter.
module tt_um_frequency_counter
   import tt_um_frequency_counter_pkg::*;
#(
   parameter int GATE_LONG  = 50_000_000,
   parameter int GATE_SHORT = 5_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [COUNT_W-1:0] result;
   logic               overflow, valid, toggle, strobe;
   logic               unused_ok;

   freq_gate_counter #(
      .GATE_LONG  (GATE_LONG),
      .GATE_SHORT (GATE_SHORT)
   ) u_gate (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig_in   (ui_in[0]),
      .range_in (ui_in[3]),
      .result   (result),
      .overflow (overflow),
      .valid    (valid),
      .toggle   (toggle),
      .strobe   (strobe)
   );

   always_comb begin
      uo_out = 8'h00;
      case (byte_sel_e'(ui_in[2:1]))
         SEL_B0:   uo_out = result[7:0];
         SEL_B1:   uo_out = result[15:8];
         SEL_B2:   uo_out = result[23:16];
         SEL_STAT: uo_out = {overflow, 6'b0, valid};
      endcase
   end

   always_comb begin
      uio_out             = 8'h00;
      uio_out[UIO_STROBE] = strobe;
      uio_out[UIO_VALID]  = valid;
      uio_out[UIO_TOGGLE] = toggle;
   end

   assign uio_oe    = UIO_OE_VAL;
   assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};

endmodule

// File: tb/tb_tt_um_frequency_counter.sv
// Directed bench for tt_um_frequency_counter with an edge-accurate window model.
module tb_tt_um_frequency_counter;

   localparam int GL = 1000;
   localparam int GS = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] ui_in, uo_out, uio_out, uio_oe;
   logic [1:0] sel = 2'b00;
   logic       rng = 1'b0;
   logic       man = 1'b0;
   logic       gen = 1'b0;
   int         mode = 0;   // 0 const0, 1 const1, 2 period 10, 3 toggle every clk, 4 manual
   logic       sig_in;

   int checks = 0;
   int errors = 0;

   // Model state: windows are spans of clk edges (W, W+G]; an input rise sampled at
   // edge e is counted at edge e+2, a range change sampled at edge e restarts at e+2.
   int   ec = 0, W = 1, cnt = 0, res = 0;
   logic mvalid = 0, mtog = 0, mstrobe = 0, mrng = 0;
   logic p1 = 0, p2 = 0, rp1 = 0, rp2 = 0, x0l = 0, x3l = 0;

   assign sig_in = (mode == 4) ? man : gen;
   assign ui_in  = {4'b0000, rng, sel, sig_in};

   tt_um_frequency_counter #(.GATE_LONG(GL), .GATE_SHORT(GS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic arr, rarr;
      if (!rst_n) begin
         ec = 0; W = 1; cnt = 0; res = 0;
         mvalid = 0; mtog = 0; mstrobe = 0; mrng = 0;
         p1 = 0; p2 = 0; rp1 = 0; rp2 = 0; x0l = 0; x3l = 0;
      end else begin
         ec++;
         arr = p2; p2 = p1; p1 = sig_in & ~x0l; x0l = sig_in;
         rarr = rp2; rp2 = rp1; rp1 = (rng != x3l); x3l = rng;
         if (rarr) begin
            mrng = ~mrng; W = ec; cnt = 0; mstrobe = 0;
         end else if (ec == W + (mrng ? GS : GL)) begin
            res = cnt + int'(arr); mvalid = 1; mtog = ~mtog; mstrobe = 1; W = ec; cnt = 0;
         end else begin
            cnt += int'(arr); mstrobe = 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   // Compare process: every cycle, away from the active edge.
   initial forever begin
      logic [7:0] exp_uo;
      @(negedge clk);
      case (sel)
         2'b00:   exp_uo = res[7:0];
         2'b01:   exp_uo = res[15:8];
         2'b10:   exp_uo = res[23:16];
         default: exp_uo = {7'b0, mvalid};
      endcase
      chk("uo_out", 32'(uo_out), 32'(exp_uo));
      chk("uio_out", 32'(uio_out), 32'({5'b0, mtog, mvalid, mstrobe}));
      chk("uio_oe", 32'(uio_oe), 32'h07);
   end

   initial begin
      int ph = 0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: gen = 1'b0;
            1: gen = 1'b1;
            2: begin
               ph = (ph == 4) ? 0 : ph + 1;
               if (ph == 0) gen = ~gen;
            end
            3: gen = ~gen;
            default: ;
         endcase
      end
   end

   task automatic wait_strobe(input int maxc, output int n);
      n = 0;
      while (n < maxc) begin
         @(negedge clk);
         n++;
         if (uio_out[0] === 1'b1) return;
      end
      chk("strobe_timeout", 32'(n), 32'(maxc + 1));
      n = -1;
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
      logic [7:0] exp [4];
      exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         chk($sformatf("%s_sel%0d", tag, s), 32'(uo_out), 32'(exp[s]));
      end
      sel = 2'b00;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_bytes("reset", 8'h00, 8'h00, 8'h00, 8'h00);
      chk("reset_uio", 32'(uio_out), 32'h00);

      // Period-10 wave, long range.
      mode = 2;
      @(negedge clk); #1 rst_n = 1'b1;
      wait_strobe(1100, n);
      wait_strobe(1100, n);
      check_bytes("p10_long", 8'h64, 8'h00, 8'h00, 8'h01);

      // Reset 500 clk into a window, between edges.
      sel = 2'b11;
      repeat (500) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_uo_sel3", 32'(uo_out), 32'h00);
      chk("rst_async_uio", 32'(uio_out), 32'h00);
      sel = 2'b00;
      #1 chk("rst_async_uo_sel0", 32'(uo_out), 32'h00);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      wait_strobe(1100, n);
      chk("rst_to_strobe", 32'(n), 32'd1001);

      // Switch to short range mid-window.
      wait_strobe(1100, n);
      repeat (300) @(posedge clk);
      #1 rng = 1'b1;
      wait_strobe(200, n);
      chk("range_switch_to_strobe", 32'(n), 32'd104);
      wait_strobe(200, n);
      check_bytes("p10_short", 8'h0A, 8'h00, 8'h00, 8'h01);

      // Maximum rate, long range.
      rng = 1'b0;
      mode = 3;
      wait_strobe(1200, n);
      wait_strobe(1200, n);
      check_bytes("maxrate", 8'hF4, 8'h01, 8'h00, 8'h01);

      // Constant high input.
      mode = 1;
      wait_strobe(1200, n);
      wait_strobe(1200, n);
      check_bytes("const1", 8'h00, 8'h00, 8'h00, 8'h01);

      // Single edge whose count lands in the terminal cycle.
      man = 1'b0;
      mode = 4;
      wait_strobe(1200, n);
      repeat (GL - 3) @(posedge clk);
      #1 man = 1'b1;
      repeat (2) @(posedge clk);
      #1 man = 1'b0;
      wait_strobe(20, n);
      chk("terminal_edge_n", 32'(n), 32'd2);
      chk("terminal_edge_win", 32'(uo_out), 32'h01);
      wait_strobe(1200, n);
      check_bytes("terminal_edge_next", 8'h00, 8'h00, 8'h00, 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tt_um_frequency_counter.md
TT_UM_FREQUENCY_COUNTER -- requirements
Module: tt_um_frequency_counter

Interface
REQ-001 Parameter GATE_LONG, default 50_000_000: clk cycles per measurement window in long range (1 s at 50 MHz).
REQ-002 Parameter GATE_SHORT, default 5_000_000: clk cycles per window in short range.
REQ-003 Port clk  input  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port ena  input  1  design-selected flag; SHALL be ignored.
REQ-006 Port ui_in  input  8  [0] signal under test (asynchronous); [2:1] output byte select; [3] range (0=long, 1=short); [7:4] unused.
REQ-007 Port uo_out  output  8  selected result byte.
REQ-008 Port uio_in  input  8  unused.
REQ-009 Port uio_out  output  8  [0] update strobe; [1] valid; [2] window toggle; [7:3] constant 0.
REQ-010 Port uio_oe  output  8  constant 8'b0000_0111.

Function
REQ-011 ui_in[0] SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected from the synchronized value and its previous sample (1-cycle detect pulse, 3 clk after the input edge).
REQ-012 A gate counter SHALL count 0..G-1, G = GATE_LONG or GATE_SHORT per ui_in[3], then wrap to 0; the cycle with count G-1 is the terminal cycle.
REQ-013 A 24-bit edge counter SHALL increment on each detect pulse and saturate at 0xFFFFFF.
REQ-014 In the terminal cycle: result <= saturating(edge_cnt + detect), overflow <= 1 if saturation occurred in the window, edge_cnt <= 0, valid <= 1, window toggle inverts, update strobe high for exactly that following cycle.
REQ-015 A detect pulse in the terminal cycle SHALL count toward the closing window, never the next one.
REQ-016 A change of ui_in[3] (sampled through the 2-flop synchronizer) SHALL restart the window: gate and edge counters cleared, result/valid unchanged, no strobe.
REQ-017 uo_out SHALL be combinational from registered state: sel 00 -> result[7:0], 01 -> result[15:8], 10 -> result[23:16], 11 -> {overflow, 6'b0, valid}.
REQ-018 Result is the number of rising edges per window; frequency = result * clk_hz / G, computed off-chip.
REQ-019 Maximum countable rate SHALL be one edge per 2 clk (input high and low at least one clk each); faster inputs are undefined.

Reset
REQ-020 rst_n low SHALL asynchronously clear synchronizers, gate counter, edge counter, result, overflow, valid, toggle, and strobe to 0.
REQ-021 During and immediately after reset, uo_out SHALL be 0x00 (any sel) and uio_out 0x00; the first window SHALL start at the first clk after deassertion.
REQ-022 Reset mid-window SHALL discard the partial count; valid SHALL return to 0 until the next terminal cycle.

Structure
REQ-023 Shared package SHALL hold COUNT_W = 24, byte-select encodings, and the uio bit-index constants.
REQ-024 One sub-module, freq_gate_counter (synchronizer, edge detect, gate/edge counters, result latch), SHALL be instantiated by the top wrapper, which contains only the output mux and port tie-offs.

Verification (bench overrides GATE_LONG=1000, GATE_SHORT=100)
REQ-025 Square wave with period 10 clk on ui_in[0], long range -> after second strobe, result 100 (sel 00 = 0x64, sel 01/10 = 0x00, sel 11 = 0x01).
REQ-026 Same wave, ui_in[3]=1 -> result 10; switching ui_in[3] mid-window produces no strobe until 100 clk after the switch is synchronized.
REQ-027 ui_in[0] toggling every clk, long range -> result 500; constant 0 or 1 input -> result 0, valid 1.
REQ-028 Edge timed so that its detect pulse lands in the terminal cycle -> counted in the closing window (window n+1 is one lower).
REQ-029 rst_n asserted at clk 500 of a window, with no clk edge -> uo_out 0x00 and uio_out 0x00 immediately; first strobe exactly 1001 clk after deassertion.
REQ-030 uio_oe == 0x07 and uio_out[7:3] == 0 throughout all scenarios.
